// File: rtl/rv_fetch_if.sv
// Instruction-memory request/grant/rvalid bus between the fetch stage and imem.
interface rv_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/rv_fetch.sv
// rv fetch stage: PC generation, credit-limited imem requests, 2-entry
// instruction buffer, and redirect flush with in-flight response discard.
module rv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rstn,
  rv_fetch_if.master       imem,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             stall_i,
  output logic             instr_valid_o,
  output logic [31:0]      instr_o,
  output logic [31:0]      pc_o,
  output logic [6:0]       opcode_o
);

  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  disc_q, disc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [31:0] buf_ins_q [2];
  logic [31:0] buf_ins_d [2];
  logic [31:0] tag_q [2];
  logic [31:0] tag_d [2];

  logic        pop, push, grant, req;
  logic [2:0]  credit;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  always_comb begin
    pop    = (count_q != 2'd0) && !stall_i && !redirect_i;
    credit = {1'b0, out_q} + {1'b0, count_q} - {2'b00, pop};
    req    = rstn && !redirect_i && (credit < 3'd2);
    grant  = req && imem.imem_gnt_i;
    push   = 1'b0;

    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    disc_d     = disc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    buf_pc_d   = buf_pc_q;
    buf_ins_d  = buf_ins_q;
    tag_d      = tag_q;

    if (redirect_i) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      out_d      = out_q - 2'(imem.imem_rvalid_i);
      disc_d     = out_q - 2'(imem.imem_rvalid_i);
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      tag_rd_d   = 1'b0;
      tag_wr_d   = 1'b0;
    end else begin
      if (grant) begin
        tag_d[tag_wr_q] = fetch_pc_q;
        tag_wr_d        = ~tag_wr_q;
        fetch_pc_d      = fetch_pc_q + 32'd4;
      end
      if (imem.imem_rvalid_i) begin
        if (disc_q != 2'd0) begin
          disc_d = disc_q - 2'd1;
        end else begin
          push                = 1'b1;
          buf_pc_d[wr_ptr_q]  = tag_q[tag_rd_q];
          buf_ins_d[wr_ptr_q] = imem.imem_rdata_i;
          wr_ptr_d            = ~wr_ptr_q;
          tag_rd_d            = ~tag_rd_q;
        end
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      out_d   = out_q + 2'(grant) - 2'(imem.imem_rvalid_i);
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q <= PC_RST;
      out_q      <= '0;
      disc_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      tag_rd_q   <= 1'b0;
      tag_wr_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_pc_q[i]  <= PC_RST;
        buf_ins_q[i] <= NOP;
        tag_q[i]     <= PC_RST;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      buf_pc_q   <= buf_pc_d;
      buf_ins_q  <= buf_ins_d;
      tag_q      <= tag_d;
    end
  end

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = fetch_pc_q;
  assign instr_valid_o    = (count_q != 2'd0);
  assign instr_o          = buf_ins_q[rd_ptr_q];
  assign pc_o             = buf_pc_q[rd_ptr_q];
  assign opcode_o         = buf_ins_q[rd_ptr_q][6:0];

endmodule
